// File: rtl/program_loader.sv
// Boot loader for the CPU's instruction memory: takes a length-prefixed byte stream,
// writes big-endian words to consecutive addresses and releases the CPU once the checksum matches.
module program_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;

  state_t      state_reg;
  logic [15:0] len_reg;
  logic [15:0] word_idx_reg;
  logic [1:0]  byte_cnt_reg;
  logic [23:0] word_reg;
  logic [7:0]  xor_reg;

  logic        accept;
  logic [15:0] len_next;
  logic [15:0] word_idx_inc;

  assign accept       = byte_valid && byte_ready;
  assign len_next     = {len_reg[15:8], byte_data};
  assign word_idx_inc = word_idx_reg + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= LEN_HI;
      len_reg      <= '0;
      word_idx_reg <= '0;
      byte_cnt_reg <= '0;
      word_reg     <= '0;
      xor_reg      <= '0;
      byte_ready   <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state_reg)
          LEN_HI: begin
            len_reg   <= {byte_data, 8'h00};
            xor_reg   <= xor_reg ^ byte_data;
            state_reg <= LEN_LO;
          end
          LEN_LO: begin
            len_reg <= len_next;
            xor_reg <= xor_reg ^ byte_data;
            if (len_next > 16'(MAX_WORDS)) begin
              state_reg  <= ERR;
              byte_ready <= 1'b0;
              err        <= 1'b1;
            end else if (len_next == 16'd0) begin
              state_reg <= CHK;
            end else begin
              state_reg <= DATA;
            end
          end
          DATA: begin
            word_reg     <= {word_reg[15:0], byte_data};
            xor_reg      <= xor_reg ^ byte_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            // Fourth byte completes the word; the write pulse appears on the following cycle.
            if (byte_cnt_reg == 2'd3) begin
              imem_we      <= 1'b1;
              imem_wdata   <= {word_reg, byte_data};
              imem_addr    <= word_idx_reg[ADDR_W-1:0];
              word_idx_reg <= word_idx_inc;
              if (word_idx_inc == len_reg)
                state_reg <= CHK;
            end
          end
          CHK: begin
            byte_ready <= 1'b0;
            if (byte_data == xor_reg) begin
              state_reg <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state_reg <= ERR;
              err       <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of byte streams with expected writes and status,
// plus hand sequences for mid-load reset and bytes offered after completion.
module tb_program_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;

  program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                wc_q[$];
  int                acc_cyc[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record every write pulse and watch the status invariants each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_we === 1'b1) begin
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_wdata);
        wc_q.push_back(cyc);
      end
      tests++;
      if ((done && err) || (cpu_reset == done)) begin
        fails++;
        $display("FAIL invariant: done=%b err=%b cpu_reset=%b", done, err, cpu_reset);
      end
    end
  end

  typedef struct {
    string       name;
    int          n;
    logic [95:0] bytes;
    bit          gappy;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        done;
    logic        err;
  } vec_t;

  localparam logic [95:0] NORMAL = 96'h0002_2001_0005_0022_1820_3C00;
  localparam logic [95:0] BADCHK = 96'h0002_2001_0005_0022_1820_3D00;
  localparam logic [41:0] RST_EXP = {1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0};

  function automatic logic [41:0] outs();
    return {byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err};
  endfunction

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    check("reset_outputs", 64'(outs()), 64'(RST_EXP));
    reset = 1'b0;
    clear_q();
  endtask

  task automatic send(input logic [95:0] b, input int n, input bit gappy);
    for (int i = 0; i < n; i++) begin
      if (gappy) begin
        int idle;
        idle = $urandom_range(0, 2);
        repeat (idle) begin
          @(negedge clk);
          byte_valid = 1'b0;
          byte_data = 8'($urandom);
        end
      end
      @(negedge clk);
      if (byte_ready !== 1'b1) begin
        check("ready_at_offer", 64'(byte_ready), 64'd1);
        byte_valid = 1'b0;
        return;
      end
      byte_valid = 1'b1;
      byte_data = b[95-8*i -: 8];
      @(posedge clk);
      #1;
      acc_cyc[i] = cyc;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Called at the negedge right after the last byte is accepted.
  task automatic check_result(input vec_t v);
    check({v.name, "_done_now"}, 64'(done), 64'(v.done));
    check({v.name, "_err_now"}, 64'(err), 64'(v.err));
    check({v.name, "_ready_now"}, 64'(byte_ready), 64'd0);
    repeat (4) @(negedge clk);
    check({v.name, "_nwr"}, 64'(wa_q.size()), 64'(v.nwr));
    for (int j = 0; j < v.nwr && j < wa_q.size(); j++) begin
      check({v.name, "_addr"}, 64'(wa_q[j]), 64'(j));
      check({v.name, "_data"}, 64'(wd_q[j]), 64'(j == 0 ? v.w0 : v.w1));
      check({v.name, "_wr_cycle"}, 64'(wc_q[j]), 64'(acc_cyc[5 + 4*j]));
    end
    check({v.name, "_status"}, 64'({done, err, cpu_reset, byte_ready}),
          64'({v.done, v.err, ~v.done, 1'b0}));
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"normal",   11, NORMAL, 1'b0, 2, 32'h20010005, 32'h00221820, 1'b1, 1'b0};
    vecs[1] = '{"bad_chk",  11, BADCHK, 1'b0, 2, 32'h20010005, 32'h00221820, 1'b0, 1'b1};
    vecs[2] = '{"zero_len",  3, 96'h0000_0000_0000_0000_0000_0000, 1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{"oversize",  2, 96'h0041_0000_0000_0000_0000_0000, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{"gappy",    11, NORMAL, 1'b1, 2, 32'h20010005, 32'h00221820, 1'b1, 1'b0};

    for (int k = 0; k < 5; k++) begin
      do_reset();
      send(vecs[k].bytes, vecs[k].n, vecs[k].gappy);
      check_result(vecs[k]);
      $display("[TB] vector %s: writes=%0d done=%b err=%b", vecs[k].name, wa_q.size(), done, err);
    end

    // Reset in the middle of a load, then a full reload.
    do_reset();
    send(NORMAL, 5, 1'b0);
    check("mid_no_write", 64'(wa_q.size()), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", 64'(outs()), 64'(RST_EXP));
    reset = 1'b0;
    clear_q();
    send(NORMAL, 11, 1'b0);
    check_result(vecs[0]);
    $display("[TB] mid-load reset then reload: writes=%0d done=%b", wa_q.size(), done);

    // Bytes offered after completion are ignored.
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_data = 8'hA5;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("sticky_nwr", 64'(wa_q.size()), 64'd2);
    check("sticky_status", 64'({done, err, cpu_reset, byte_ready}), 64'(4'b1000));
    $display("[TB] bytes after done: writes=%0d done=%b", wa_q.size(), done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
